// File: rtl/io_pkg.sv
// Shared I/O port numbering and word type for the CPU port space.
// Input-side numbers select in_data sources; output-side numbers are used by the display logic.
package io_pkg;

    typedef logic [15:0] io_word_t;

    localparam logic [3:0] PORT_BTN_EVENTS = 4'd0;
    localparam logic [3:0] PORT_BTN_LEVELS = 4'd1;
    localparam logic [3:0] PORT_TICKS      = 4'd2;

    localparam logic [3:0] PORT_SECONDS = 4'd0;
    localparam logic [3:0] PORT_MINUTES = 4'd1;
    localparam logic [3:0] PORT_HOURS   = 4'd2;
    localparam logic [3:0] PORT_DAYS    = 4'd3;
    localparam logic [3:0] PORT_MONTHS  = 4'd4;
    localparam logic [3:0] PORT_YEARS   = 4'd5;

endpackage

// File: rtl/button_debounce.sv
// One push-button: synchroniser, stability counter and debounced level.
// press pulses in the cycle whose closing edge accepts a new pressed level.
module button_debounce #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic PIN_RELEASED = ACTIVE_LOW;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pressed_raw;

    assign pressed_raw = sync_q[SYNC_STAGES-1] ^ PIN_RELEASED;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
        cnt_d   = '0;
        level_d = level_q;
        press   = 1'b0;
        if (pressed_raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press   = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= {SYNC_STAGES{PIN_RELEASED}};
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/cpu_input_port.sv
// CPU input port: debounced buttons with sticky press events and a saturating tick count,
// exposed as 16-bit words in I/O port space; reads of ports 0 and 2 consume their contents.
module cpu_input_port
    import io_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int ACTIVE_LOW      = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_DIVISOR    = 50000000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [3:0]             in_port,
    input  logic                   read_in,
    output logic [15:0]            in_data,
    output logic                   tick
);

    localparam int DW = $clog2(TICK_DIVISOR);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIVISOR - 1);

    logic [NUM_BUTTONS-1:0] level, press;
    logic [NUM_BUTTONS-1:0] event_q, event_d;
    logic [DW-1:0]          div_q, div_d;
    logic [7:0]             tcnt_q, tcnt_d;
    logic [8:0]             tsum;
    logic                   tick_now, rd_events, rd_ticks;
    io_word_t               rd_word;

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
        button_debounce #(
            .ACTIVE_LOW     (ACTIVE_LOW != 0),
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rstn (rstn),
            .pin  (buttons[gi]),
            .level(level[gi]),
            .press(press[gi])
        );
    end

    assign tick_now  = (div_q == DIV_LAST);
    assign rd_events = read_in && (in_port == PORT_BTN_EVENTS);
    assign rd_ticks  = read_in && (in_port == PORT_TICKS);

    // A press accepted in the same cycle as a consuming read must survive the clear.
    always_comb begin
        div_d   = tick_now ? '0 : div_q + 1'b1;
        event_d = (event_q & ~{NUM_BUTTONS{rd_events}}) | press;
        tsum    = {1'b0, tcnt_q} - (rd_ticks ? {1'b0, tcnt_q} : 9'd0) + {8'd0, tick_now};
        tcnt_d  = tsum[8] ? 8'hFF : tsum[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            event_q <= '0;
            div_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            event_q <= event_d;
            div_q   <= div_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        rd_word = '0;
        case (in_port)
            PORT_BTN_EVENTS: rd_word[NUM_BUTTONS-1:0] = event_q;
            PORT_BTN_LEVELS: rd_word[NUM_BUTTONS-1:0] = level;
            PORT_TICKS:      rd_word[7:0] = tcnt_q;
            default:         rd_word = '0;
        endcase
    end

    assign in_data = rd_word;
    assign tick    = tick_now;

endmodule

// File: tb/tb_cpu_input_port.sv
// Bench for cpu_input_port: hand-computed vector table, directed tick/reset sequences,
// and random button/read traffic compared every cycle against a behavioural model.
module tb_cpu_input_port;

    localparam int NB = 3;
    localparam int DB = 4;
    localparam int TD = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic [NB-1:0] buttons;
    logic [3:0]    in_port;
    logic          read_in;
    logic [15:0]   in_data;
    logic          tick;

    always #5 clk = ~clk;

    cpu_input_port #(
        .NUM_BUTTONS    (NB),
        .ACTIVE_LOW     (1),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIVISOR   (TD)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .buttons(buttons),
        .in_port(in_port),
        .read_in(read_in),
        .in_data(in_data),
        .tick   (tick)
    );

    int total = 0;
    int bad   = 0;

    // Model: a level flips once the last DB synchronised samples all disagree with it.
    logic [NB-1:0] pin_h0, pin_h1;
    logic [DB-1:0] raw_hist [NB];
    int            nvalid;
    logic [NB-1:0] m_lvl, m_evt;
    int            m_cnt;
    int            m_e;

    task automatic model_reset();
        pin_h0 = '1;
        pin_h1 = '1;
        for (int i = 0; i < NB; i++) raw_hist[i] = '0;
        nvalid = 0;
        m_lvl  = '0;
        m_evt  = '0;
        m_cnt  = 0;
        m_e    = 0;
    endtask

    function automatic logic m_tick();
        return (m_e % TD) == TD - 1;
    endfunction

    function automatic logic [15:0] m_data(input logic [3:0] p);
        case (p)
            4'd0:    return {13'd0, m_evt};
            4'd1:    return {13'd0, m_lvl};
            4'd2:    return 16'(m_cnt);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge(input logic [NB-1:0] b, input logic [3:0] p, input logic rd);
        logic          tk;
        logic [NB-1:0] raw, prs;
        int            ret;
        tk     = m_tick();
        raw    = ~pin_h0;
        pin_h0 = pin_h1;
        pin_h1 = b;
        nvalid++;
        prs = '0;
        for (int i = 0; i < NB; i++) begin
            raw_hist[i] = {raw_hist[i][DB-2:0], raw[i]};
            if (nvalid >= DB && raw_hist[i] == {DB{~m_lvl[i]}}) begin
                m_lvl[i] = ~m_lvl[i];
                prs[i]   = m_lvl[i];
            end
        end
        if (rd && p == 4'd0) m_evt = '0;
        m_evt = m_evt | prs;
        ret   = (rd && p == 4'd2) ? m_cnt : 0;
        m_cnt = m_cnt - ret + (tk ? 1 : 0);
        if (m_cnt > 255) m_cnt = 255;
        m_e++;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic [NB-1:0] b, input logic [3:0] p, input logic rd,
                        output logic [15:0] got, output logic tk);
        @(negedge clk);
        buttons = b;
        in_port = p;
        read_in = rd;
        #1;
        got = in_data;
        tk  = tick;
        check("model_data", in_data, m_data(p));
        check("model_tick", {15'd0, tick}, {15'd0, m_tick()});
        @(posedge clk);
        model_edge(b, p, rd);
    endtask

    typedef struct {
        logic [NB-1:0] btn;
        logic [3:0]    port;
        logic          rd;
        int            n;
        logic [15:0]   exp;
    } vec_t;

    vec_t vecs [23];

    task automatic release_reset();
        buttons = '1;
        in_port = 4'd0;
        read_in = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] got;
        logic        tk;
        int          ticks;
        logic [NB-1:0] b;

        vecs[0]  = '{3'b111, 4'd0, 1'b0, 1, 16'h0};
        vecs[1]  = '{3'b111, 4'd1, 1'b0, 1, 16'h0};
        vecs[2]  = '{3'b111, 4'd2, 1'b0, 1, 16'h0};
        vecs[3]  = '{3'b111, 4'd7, 1'b0, 1, 16'h0};
        vecs[4]  = '{3'b110, 4'd1, 1'b0, 3, 16'h0};
        vecs[5]  = '{3'b111, 4'd1, 1'b0, 4, 16'h0};
        vecs[6]  = '{3'b111, 4'd0, 1'b0, 1, 16'h0};
        vecs[7]  = '{3'b110, 4'd1, 1'b0, 8, 16'h1};
        vecs[8]  = '{3'b110, 4'd0, 1'b0, 1, 16'h1};
        vecs[9]  = '{3'b111, 4'd1, 1'b0, 8, 16'h0};
        vecs[10] = '{3'b010, 4'd0, 1'b0, 8, 16'h5};
        vecs[11] = '{3'b111, 4'd1, 1'b0, 8, 16'h0};
        vecs[12] = '{3'b110, 4'd0, 1'b0, 8, 16'h5};
        vecs[13] = '{3'b110, 4'd0, 1'b1, 1, 16'h5};
        vecs[14] = '{3'b110, 4'd0, 1'b0, 1, 16'h0};
        vecs[15] = '{3'b100, 4'd1, 1'b0, 5, 16'h1};
        vecs[16] = '{3'b100, 4'd0, 1'b1, 1, 16'h0};
        vecs[17] = '{3'b100, 4'd0, 1'b0, 1, 16'h2};
        vecs[18] = '{3'b100, 4'd1, 1'b0, 1, 16'h3};
        vecs[19] = '{3'b100, 4'd1, 1'b1, 1, 16'h3};
        vecs[20] = '{3'b100, 4'd9, 1'b1, 1, 16'h0};
        vecs[21] = '{3'b100, 4'd0, 1'b0, 1, 16'h2};
        vecs[22] = '{3'b100, 4'd2, 1'b0, 1, 16'h6};

        rstn    = 1'b0;
        buttons = '1;
        in_port = 4'd0;
        read_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_data", in_data, 16'h0);
        check("reset_tick", {15'd0, tick}, 16'h0);
        release_reset();

        for (int v = 0; v < 23; v++) begin
            for (int k = 0; k < vecs[v].n; k++)
                step(vecs[v].btn, vecs[v].port, vecs[v].rd, got, tk);
            check($sformatf("vec%0d", v), got, vecs[v].exp);
        end

        // Tick counting from a fresh reset.
        rstn = 1'b0;
        release_reset();
        ticks = 0;
        for (int k = 0; k < 35; k++) begin
            step(3'b111, 4'd2, 1'b0, got, tk);
            if (tk) ticks++;
        end
        check("tick_pulses_35", 16'(ticks), 16'd3);
        step(3'b111, 4'd2, 1'b0, got, tk);
        check("ticks_after_35", got, 16'd3);
        repeat (3) step(3'b111, 4'd2, 1'b0, got, tk);
        step(3'b111, 4'd2, 1'b1, got, tk);
        check("read_on_tick_val", got, 16'd3);
        check("read_on_tick_pulse", {15'd0, tk}, 16'd1);
        step(3'b111, 4'd2, 1'b0, got, tk);
        check("after_read_on_tick", got, 16'd1);
        repeat (2600) step(3'b111, 4'd2, 1'b0, got, tk);
        step(3'b111, 4'd2, 1'b0, got, tk);
        check("ticks_saturate", got, 16'd255);

        // Asynchronous reset mid-divide and mid-debounce.
        repeat (8) step(3'b101, 4'd1, 1'b0, got, tk);
        repeat (3) step(3'b011, 4'd1, 1'b0, got, tk);
        @(negedge clk);
        #1 rstn = 1'b0;
        for (int p = 0; p < 3; p++) begin
            in_port = 4'(p);
            #1 check($sformatf("async_rst_port%0d", p), in_data, 16'h0);
        end
        check("async_rst_tick", {15'd0, tick}, 16'h0);
        release_reset();

        // Random traffic against the model.
        b = '1;
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] p;
            if ($urandom_range(7) == 0) b[$urandom_range(NB - 1)] ^= 1'b1;
            p = ($urandom_range(9) == 0) ? 4'd9 : 4'($urandom_range(3));
            step(b, p, ($urandom_range(3) == 0), got, tk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_input_port.md
Name: cpu_input_port

Overview:
- Input-side counterpart to the CPU output-port writes: it produces the `in_data` word the Driver reads from I/O port space.
- Synchronises and debounces the board push-buttons, latches press events until the program consumes them, and provides a free-running 1 Hz tick count.
- The timekeeping firmware uses it to advance the clock and to edit the time with the buttons.
- Sits at FPGA top level, between the raw `buttons` pins and the Driver's `in_port`/`in_data`/`read_in` interface.

Parameters:
- NUM_BUTTONS, 3, number of button inputs (1..16).
- ACTIVE_LOW, 1, 1 = button pins read 0 when pressed.
- SYNC_STAGES, 2, flip-flop synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level.
- TICK_DIVISOR, 50000000, clk cycles per tick (1 Hz at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- buttons  in  NUM_BUTTONS  raw asynchronous button pins.
- in_port  in  4  port selected by the executing IN instruction.
- read_in  in  1  one-cycle strobe: the CPU consumes the selected port this cycle.
- in_data  out  16  read data for `in_port`; combinational from registered state.
- tick  out  1  one-cycle pulse on each tick (debug/LED).

Behaviour:
- Reset (rstn=0, async):
  - synchroniser and debounced levels = released;
  - debounce counters, event flags, divider, tick count = 0;
  - tick = 0; in_data reflects zeroed state.
  - Reset mid-debounce or mid-divide discards all progress.
- Synchroniser: SYNC_STAGES FFs per button, then inversion if ACTIVE_LOW. The result `pressed_raw` is 1 when the button is pressed.
- Debounce, per button:
  - Counter counts while `pressed_raw` != debounced level and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Pin-to-level latency = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Event flags, per button:
  - Set on a 0->1 transition of the debounced level (press). Release sets nothing.
  - Sticky: repeated presses before a read still leave the flag at 1.
  - Cleared by read_in=1 with in_port=0.
  - Set and clear in the same cycle: set wins, so the flag stays 1.
- Tick:
  - Divider counts 0..TICK_DIVISOR-1 and wraps.
  - At wrap, tick=1 for one cycle and the tick count increments.
  - Tick count is 8 bits and saturates at 255 (no wrap).
- Port map, in_data (unused high bits = 0):
  - 0: event flags [NUM_BUTTONS-1:0].
  - 1: debounced levels [NUM_BUTTONS-1:0]; reading has no side effect.
  - 2: {8'b0, tick_count}.
  - 3..15: 16'h0000; reads have no side effect.
- Consume of port 2 (read_in=1, in_port=2):
  - tick_count <= tick_count - value_returned + tick_this_cycle.
  - A tick coinciding with the read is never lost: a count of 3 with a tick in the read cycle becomes 1.
- read_in handshake:
  - Data is valid in the same cycle as the strobe; side effects land at the following posedge.
  - read_in held high for N cycles consumes N times; the second read returns the already-cleared value.
- Width rules: DEBOUNCE_CYCLES and TICK_DIVISOR counters are sized by $clog2 of the parameter; parameters >= 2.

Decomposition:
- Shared package `io_pkg`, containing:
  - port-number constants: PORT_BTN_EVENTS=0, PORT_BTN_LEVELS=1, PORT_TICKS=2;
  - typedef `io_word_t` = logic [15:0];
  - output-port constants PORT_SECONDS..PORT_YEARS = 0..5, for use by the display side.
- One natural sub-module, `button_debounce`: one button covering synchroniser, counter and debounced level, with a press-pulse output. It is instantiated NUM_BUTTONS times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIVISOR=10, SYNC_STAGES=2, ACTIVE_LOW=1):
- Reset and levels: deassert rstn with buttons=3'b111 -> in_data=0 on ports 0, 1, 2 and 7; tick=0; then assert rstn=0 asynchronously mid-count -> all state 0 immediately.
- Debounce: drive buttons[0]=0 for 3 cycles, then back to 1 -> port 1 stays 0 and port 0 stays 0. Hold low for 8 cycles -> port 1 = 3'b001 by cycle 6 after the edge, and port 0 = 3'b001.
- Sticky and consume: press buttons 0 and 2, release both, press button 0 again -> port 0 = 3'b101. Pulse read_in with in_port=0 -> in_data=5 in that cycle, then 0 on the next cycle.
- Set/clear collision: time read_in on port 0 to the same cycle as button-1 press acceptance -> flag 1 remains set afterwards (port 0 = 3'b010).
- Tick count: run 35 cycles after reset -> 3 tick pulses, port 2 = 3. Read port 2 on the cycle of the 4th tick -> returns 3, then port 2 = 1. Run 2600 cycles unread -> port 2 = 255, with no wrap.
- Unused port and side-effect-free read: read_in with in_port=1 or 9 -> events and tick count unchanged; port 9 returns 0.
